// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the button debouncer and related board-input logic.
package btn_debounce_pkg;

  // Debouncer FSM state; all four encodings are in use.
  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } btn_state_e;

  // 10 ms qualification window at a 100 MHz clock.
  localparam int unsigned DEBOUNCE_CNT_100MHZ = 1000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync_2ff
  import btn_debounce_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-flop synchroniser followed by a counter-qualified FSM.
// btn_level follows the synchronised input only after it has held a new value for
// CNT_MAX consecutive FSM evaluations beyond the first. Optional macro
// BTN_DEBOUNCE_GLITCH_CNT_EN adds an 8-bit saturating count of aborted qualifications.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned CNT_MAX = DEBOUNCE_CNT_100MHZ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       bouncing
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             sync_q2;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort;
  logic             level_d, bouncing_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (sync_q2)
  );

  // Next-state, qualification counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    abort   = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync_q2) state_d = S_RISE;
      end
      S_RISE: begin
        if (!sync_q2) begin
          state_d = S_LOW;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync_q2) state_d = S_FALL;
      end
      S_FALL: begin
        if (sync_q2) begin
          state_d = S_HIGH;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_LOW;
    endcase
    // Outputs are decoded from the next state so they land in flops alongside it.
    level_d    = (state_d == S_HIGH) || (state_d == S_FALL);
    bouncing_d = (state_d == S_RISE) || (state_d == S_FALL);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      btn_level <= 1'b0;
      bouncing  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_level <= level_d;
      bouncing  <= bouncing_d;
    end
  end

`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_q;

  // Saturating count of aborted qualifications; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= 8'd0;
    end else if (abort && (glitch_q != 8'hFF)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with CNT_MAX=4: a run-length model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_btn_debounce;

  localparam int unsigned CNT_MAX = 4;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       btn_level;
  logic       bouncing;
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int tests;
  int fails;
  bit running;

  btn_debounce #(.CNT_MAX(CNT_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .bouncing  (bouncing)
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the FSM sees btn_in two edges late; level flips once the seen value has
  // disagreed with it for CNT_MAX+1 consecutive edges. Any agreeing sample mid-run aborts.
  logic [1:0] m_hist;
  logic       m_level;
  int         m_run;
  int         m_glitch;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hist   <= 2'b00;
      m_level  <= 1'b0;
      m_run    <= 0;
      m_glitch <= 0;
    end else begin
      m_hist <= {m_hist[0], btn_in};
      if (m_hist[1] != m_level) begin
        if (m_run + 1 == int'(CNT_MAX) + 1) begin
          m_level <= m_hist[1];
          m_run   <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch <= m_glitch + 1;
        m_run <= 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (running) begin
      check("model_level", int'(btn_level), int'(m_level));
      check("model_bouncing", int'(bouncing), int'(m_run != 0));
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
      check("model_glitch", int'(glitch_cnt), m_glitch);
`endif
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    btn_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    running = 1'b1;
    rst_n   = 1'b0;
    btn_in  = 1'b1;

    // Reset hold with the button pressed.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("rst_level", int'(btn_level), 0);
      check("rst_bouncing", int'(bouncing), 0);
    end
    btn_in = 1'b0;
    rst_n  = 1'b1;
    tick(3);

    // Clean press: sampled at edge k.
    btn_in = 1'b1;
    tick(1);
    tick(1);
    check("press_k1_bouncing", int'(bouncing), 0);
    tick(1);
    check("press_k2_bouncing", int'(bouncing), 1);
    check("press_k2_level", int'(btn_level), 0);
    tick(3);
    check("press_k5_level", int'(btn_level), 0);
    tick(1);
    check("press_k6_level", int'(btn_level), 1);
    check("press_k6_bouncing", int'(bouncing), 0);
    tick(14);

    // Release with a one-cycle blip during S_FALL: new stable-low sample at k+4.
    btn_in = 1'b0;
    tick(3);
    check("rel_k2_bouncing", int'(bouncing), 1);
    btn_in = 1'b1;
    tick(1);
    btn_in = 1'b0;
    tick(2);
    check("rel_k5_aborted", int'(bouncing), 0);
    check("rel_k5_level", int'(btn_level), 1);
    tick(4);
    check("rel_k9_level", int'(btn_level), 1);
    tick(1);
    check("rel_k10_level", int'(btn_level), 0);
    tick(4);

    // Short glitch of exactly CNT_MAX cycles must not change the level.
    btn_in = 1'b1;
    tick(4);
    btn_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("short_level", int'(btn_level), 0);
    end
    check("short_idle", int'(bouncing), 0);

    // Bounce rejection from a fresh reset.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      btn_in = ((i / 2) % 2 == 0);
      tick(1);
      check("bounce_level", int'(btn_level), 0);
    end
    btn_in = 1'b1;
    tick(6);
    check("bounce_k5_level", int'(btn_level), 0);
    tick(1);
    check("bounce_k6_level", int'(btn_level), 1);
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
    check("bounce_glitch_cnt", int'(glitch_cnt), 2);
`endif

    // Reset mid-qualification (S_RISE, cnt=2), button held across release.
    do_reset();
    btn_in = 1'b1;
    tick(5);
    check("mid_bouncing", int'(bouncing), 1);
    rst_n = 1'b0;
    tick(2);
    check("mid_rst_level", int'(btn_level), 0);
    check("mid_rst_bouncing", int'(bouncing), 0);
    rst_n = 1'b1;
    tick(6);
    check("mid_j5_level", int'(btn_level), 0);
    tick(1);
    check("mid_j6_level", int'(btn_level), 1);

    tick(2);
    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Upstream conditioning stage for the rising-edge pulse generator.
- Takes a raw, asynchronous, bouncing push-button or switch input.
- Synchronises it into clk and confirms stability with a counter-qualified FSM.
- Drives a clean registered level (btn_level) that the edge detector converts into a single-cycle pulse.

Parameters:
- CNT_MAX, 1000000: clk cycles the synchronised input must hold a new value before btn_level follows (10 ms at 100 MHz). Legal range is CNT_MAX >= 2.
- CNT_W, $clog2(CNT_MAX): counter width. Derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_in  input  1  raw asynchronous button/switch level; may bounce.
- btn_level  output  1  debounced registered level; feeds the edge detector's input.
- bouncing  output  1  high while a candidate transition is being qualified (states S_RISE and S_FALL).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync_q1 = sync_q2 = 0; state = S_LOW; cnt = 0.
  - btn_level = 0; bouncing = 0.
  - All outputs are registered; no combinational path from btn_in to any output.
- Synchroniser: btn_in -> sync_q1 -> sync_q2, two flops. The FSM sees only sync_q2.
- FSM states, evaluated each clk edge:
  - S_LOW: btn_level=0. If sync_q2=1, go to S_RISE with cnt=0; else stay.
  - S_RISE:
    - If sync_q2=0: abort to S_LOW (glitch), cnt=0.
    - Else if cnt==CNT_MAX-1: go to S_HIGH with btn_level=1, cnt=0.
    - Else cnt++.
  - S_HIGH: btn_level=1. If sync_q2=0, go to S_FALL with cnt=0.
  - S_FALL: mirror of S_RISE with polarity swapped.
    - If sync_q2=1: abort to S_HIGH.
    - Else if cnt==CNT_MAX-1: go to S_LOW with btn_level=0.
    - Else cnt++.
- Latency: let edge k be the first edge at which btn_in is sampled high and it stays high. btn_level is 1 after edge k+CNT_MAX+2. Falling latency is identical.
- A pulse on btn_in shorter than CNT_MAX+1 cycles never changes btn_level. Any single contrary sample of sync_q2 restarts qualification from zero.
- btn_level changes only on state entry to S_HIGH/S_LOW: at most one change per qualified transition, so there is no double pulse downstream.
- cnt never exceeds CNT_MAX-1 and never wraps; cnt is held at 0 in S_LOW/S_HIGH.
- Reset mid-qualification: all state is discarded. If btn_in is held high across rst_n release, the full CNT_MAX+2 qualification repeats before btn_level=1.
- Illegal/unused FSM encodings recover to S_LOW with btn_level=0 on the next edge.

Optional Feature:
- Macro: BTN_DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Adds output port glitch_cnt, 8 bits.
  - Increments once per aborted qualification (S_RISE->S_LOW or S_FALL->S_HIGH).
  - Saturates at 255; reset value 0; cleared only by rst_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state typedef, 2-bit enum: S_LOW=0, S_RISE=1, S_HIGH=2, S_FALL=3.
  - default debounce constant DEBOUNCE_CNT_100MHZ=1000000.
- One sub-module is natural: sync_2ff.
  - 2-flop synchroniser with clk and rst_n; reset value 0.
  - Reused for other asynchronous board inputs.
- FSM and counter stay in btn_debounce.

Test Plan (CNT_MAX=4 for simulation):
- Reset hold: rst_n=0 with btn_in=1 for 10 cycles -> btn_level=0, bouncing=0 throughout.
- Clean press: btn_in 0->1 held 20 cycles, first sampled at edge k -> bouncing=1 from edge k+2; btn_level=1 exactly after edge k+6; bouncing=0 at the same edge.
- Bounce rejection: btn_in toggles 1,0,1,0 each 2 cycles, then held 1 -> btn_level stays 0 during toggling; rises 6 edges after the final stable-high sample. With the macro defined, glitch_cnt=2.
- Short glitch: btn_in high for exactly 4 cycles, then low -> btn_level never asserts; FSM returns to S_LOW.
- Release: from S_HIGH, btn_in 1->0 held -> btn_level=0 after 6 edges; a 1-cycle high blip during S_FALL restarts the count, adding the blip delay.
- Reset mid-qualification: assert rst_n=0 while in S_RISE with cnt=2, release with btn_in still 1 -> btn_level=1 only after the full 6 edges from the first post-release sample.
